// File: rtl/counter_ctrl_pkg.sv
// counter_ctrl_pkg: shared state encoding and mode constants for the counter controller.
package counter_ctrl_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } state_e;
    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;
endpackage

// File: rtl/counter_ctrl_if.sv
// counter_ctrl_if: control/status bundle between CSR logic (master) and counter_ctrl (slave).
// The presc divisor exists only with COUNTER_CTRL_PRESCALE_EN.
interface counter_ctrl_if #(
    parameter int WIDTH = 4
`ifdef COUNTER_CTRL_PRESCALE_EN
    , parameter int PRESC_W = 4
`endif
) ();
    logic             start, stop, hold, mode, irq_clr;
    logic [WIDTH-1:0] limit, count;
    logic [1:0]       state;
    logic             busy, tc, irq;
`ifdef COUNTER_CTRL_PRESCALE_EN
    logic [PRESC_W-1:0] presc;
`endif
    modport master (
        output start, stop, hold, mode, irq_clr, limit,
`ifdef COUNTER_CTRL_PRESCALE_EN
        output presc,
`endif
        input count, state, busy, tc, irq
    );
    modport slave (
        input start, stop, hold, mode, irq_clr, limit,
`ifdef COUNTER_CTRL_PRESCALE_EN
        input presc,
`endif
        output count, state, busy, tc, irq
    );
endinterface

// File: rtl/counter_ctrl_presc.sv
// counter_ctrl_presc: tick divider, built only with COUNTER_CTRL_PRESCALE_EN.
`ifdef COUNTER_CTRL_PRESCALE_EN
module counter_ctrl_presc #(
    parameter int PRESC_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               en,
    input  logic [PRESC_W-1:0] presc,
    output logic               tick
);
    logic [PRESC_W-1:0] div_q, div_d;
    assign tick = div_q == presc;
    always_comb begin
        div_d = clr ? '0 : en ? (tick ? '0 : div_q + PRESC_W'(1)) : div_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) div_q <= '0;
        else     div_q <= div_d;
    end
endmodule
`endif

// File: rtl/counter_ctrl.sv
// counter_ctrl: start/stop/hold sequencer owning the count register, with terminal-count strobe and sticky irq.
// Define COUNTER_CTRL_PRESCALE_EN to divide the count tick by presc+1.
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
`ifdef COUNTER_CTRL_PRESCALE_EN
    , parameter int PRESC_W = 4
`endif
) (
    input logic           clk,
    input logic           rst,
    counter_ctrl_if.slave bus
);
    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d, limit_q, limit_d;
    logic             mode_q, mode_d, irq_q, irq_d, busy_q, busy_d;
    logic             tick, tc;
`ifdef COUNTER_CTRL_PRESCALE_EN
    counter_ctrl_presc #(.PRESC_W(PRESC_W)) u_presc (
        .clk   (clk),
        .rst   (rst),
        .clr   (bus.start | bus.stop),
        .en    (state_q == ST_RUN && !bus.hold),
        .presc (bus.presc),
        .tick  (tick)
    );
`else
    assign tick = 1'b1;
`endif
    assign tc = state_q == ST_RUN && tick && !bus.hold && count_q == limit_q;
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        limit_d = limit_q;
        mode_d  = mode_q;
        irq_d   = tc | (irq_q & ~bus.irq_clr);
        if (bus.stop) begin
            state_d = ST_IDLE;
            count_d = '0;
        end else if (bus.start) begin
            state_d = ST_RUN;
            count_d = '0;
            limit_d = bus.limit;
            mode_d  = bus.mode;
        end else if (state_q == ST_RUN) begin
            if (bus.hold) state_d = ST_HOLD;
            else if (tc) begin
                // periodic wraps to zero; one-shot parks at limit in DONE
                count_d = (mode_q == MODE_PERIODIC) ? '0 : count_q;
                state_d = (mode_q == MODE_PERIODIC) ? ST_RUN : ST_DONE;
            end else if (tick) count_d = count_q + WIDTH'(1);
        end else if (state_q == ST_HOLD && !bus.hold) state_d = ST_RUN;
        busy_d = state_d == ST_RUN || state_d == ST_HOLD;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            limit_q <= '0;
            mode_q  <= MODE_ONESHOT;
            irq_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            limit_q <= limit_d;
            mode_q  <= mode_d;
            irq_q   <= irq_d;
            busy_q  <= busy_d;
        end
    end
    assign bus.count = count_q;
    assign bus.state = state_q;
    assign bus.busy  = busy_q;
    assign bus.tc    = tc;
    assign bus.irq   = irq_q;
endmodule

// File: tb/tb_counter_ctrl.sv
// tb_counter_ctrl: directed plus random stimulus against a tick-counting reference model.
module tb_counter_ctrl;
    import counter_ctrl_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;
    counter_ctrl_if bus ();
    counter_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    // model: state per spec encoding, ticks counted since the last start
    int m_st, m_ticks, m_lim;
    bit m_per, m_irq, hl;
`ifdef COUNTER_CTRL_PRESCALE_EN
    int m_div, m_presc;
`endif
    function automatic int m_count();
        if (m_per) return m_ticks % (m_lim + 1);
        return m_ticks < m_lim ? m_ticks : m_lim;
    endfunction
    function automatic bit m_tick();
`ifdef COUNTER_CTRL_PRESCALE_EN
        return m_div == m_presc;
`else
        return 1'b1;
`endif
    endfunction
    task automatic m_reset();
        m_st = 0; m_ticks = 0; m_lim = 0; m_per = 0; m_irq = 0;
`ifdef COUNTER_CTRL_PRESCALE_EN
        m_div = 0;
`endif
    endtask
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask
    task automatic cyc(input bit s, input bit p, input bit h, input bit m, input int l, input bit c);
        bit tc_e, tk;
        bus.start = s; bus.stop = p; bus.hold = h; bus.mode = m; bus.limit = 4'(l); bus.irq_clr = c;
        #1;
        tk = m_tick();
        tc_e = m_st == 1 && tk && !h && m_count() == m_lim;
        chk("tc", bus.tc, tc_e);
        @(posedge clk);
        m_irq = tc_e | (m_irq & !c);
        if (p || s) begin
            m_st = p ? 0 : 1;
            m_ticks = 0;
            if (!p) begin m_lim = l; m_per = m; end
`ifdef COUNTER_CTRL_PRESCALE_EN
            m_div = 0;
`endif
        end else if (m_st == 1) begin
            if (h) m_st = 2;
            else begin
                if (tk) begin
                    if (!m_per && m_ticks == m_lim) m_st = 3;
                    else m_ticks++;
                end
`ifdef COUNTER_CTRL_PRESCALE_EN
                m_div = tk ? 0 : m_div + 1;
`endif
            end
        end else if (m_st == 2 && !h) m_st = 1;
        @(negedge clk);
        chk("count", bus.count, m_count());
        chk("state", bus.state, m_st);
        chk("busy", bus.busy, m_st == 1 || m_st == 2);
        chk("irq", bus.irq, m_irq);
    endtask
    initial begin
        bus.start = 0; bus.stop = 0; bus.hold = 0; bus.mode = 0; bus.limit = 0; bus.irq_clr = 0;
`ifdef COUNTER_CTRL_PRESCALE_EN
        m_presc = 0; bus.presc = 0;
`endif
        m_reset();
        repeat (2) @(negedge clk);
        chk("rst_count", bus.count, 0);
        chk("rst_state", bus.state, ST_IDLE);
        chk("rst_busy", bus.busy, 0);
        chk("rst_irq", bus.irq, 0);
        chk("rst_tc", bus.tc, 0);
        rst = 0;
        cyc(1, 0, 0, 0, 5, 0);
        repeat (8) cyc(0, 0, 0, 0, 5, 0);
        chk("os_state", bus.state, ST_DONE);
        chk("os_count", bus.count, 5);
        chk("os_irq", bus.irq, 1);
        chk("os_busy", bus.busy, 0);
        cyc(1, 0, 0, 1, 3, 1);
        for (int i = 0; i < 12; i++) cyc(0, 0, 0, 1, 3, i == 3 || i == 8);
        cyc(1, 0, 0, 1, 7, 0);
        repeat (4) cyc(0, 0, 0, 1, 7, 0);
        repeat (3) cyc(0, 0, 1, 1, 7, 0);
        chk("hold_count", bus.count, 4);
        cyc(0, 0, 0, 1, 7, 0);
        cyc(0, 0, 0, 1, 7, 0);
        chk("resume_count", bus.count, 5);
        cyc(1, 0, 0, 1, 9, 0);
        repeat (2) cyc(0, 0, 0, 1, 9, 0);
        cyc(1, 1, 0, 1, 9, 0);
        chk("startstop_state", bus.state, ST_IDLE);
        cyc(1, 0, 0, 0, 0, 0);
        repeat (2) cyc(0, 0, 0, 0, 0, 0);
        chk("lim0_state", bus.state, ST_DONE);
        cyc(1, 0, 0, 0, 9, 0);
        repeat (6) cyc(0, 0, 0, 0, 9, 0);
        #2 rst = 1;
        #1;
        chk("arst_count", bus.count, 0);
        chk("arst_state", bus.state, ST_IDLE);
        chk("arst_irq", bus.irq, 0);
        chk("arst_busy", bus.busy, 0);
        m_reset();
        @(negedge clk);
        rst = 0;
`ifdef COUNTER_CTRL_PRESCALE_EN
        m_presc = 2; bus.presc = 2;
        cyc(1, 0, 0, 1, 2, 0);
        repeat (13) cyc(0, 0, 0, 1, 2, 0);
        repeat (2) cyc(0, 0, 1, 1, 2, 0);
        repeat (10) cyc(0, 0, 0, 1, 2, 0);
`endif
        hl = 0;
        repeat (400) begin
            if ($urandom_range(0, 5) == 0) hl = !hl;
`ifdef COUNTER_CTRL_PRESCALE_EN
            if ($urandom_range(0, 30) == 0) begin
                m_presc = $urandom_range(0, 3);
                bus.presc = 4'(m_presc);
            end
`endif
            cyc($urandom_range(0, 14) == 0, $urandom_range(0, 29) == 0, hl, 1'($urandom_range(0, 1)),
                $urandom_range(0, 3) == 0 ? $urandom_range(0, 15) : $urandom_range(0, 4),
                $urandom_range(0, 9) == 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
